lbp_scan_ctrl: RTL and testbench

Sequencing and window-receive block for the LBP engine. It drives the gray address generator's control interface: initialize, fill_right, fill_down, fill_left, gray_addr_en, cycle and lbp_addr. It captures the returned gray pixels into a 3×3 window, computes the 8-bit LBP code, and writes it to the LBP memory. The scan is a serpentine over the 126×126 interior of a 128×128 image. The lbp_addr register is triple-redundant with per-bit majority vote.

---
 rtl/lbp_scan_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_lbp_scan_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_scan_ctrl.sv
// LBP engine scan sequencer: serpentine walk over the image interior,
// 3x3 window receive, LBP code generation and TMR-protected write address.
module lbp_scan_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        gray_ready,
  input  logic [7:0]  gray_data,
  output logic        gray_req,
  output logic        initialize,
  output logic        fill_right,
  output logic        fill_down,
  output logic        fill_left,
  output logic        gray_addr_en,
  output logic [3:0]  cycle,
  output logic [13:0] lbp_addr,
  output logic        lbp_valid,
  output logic [7:0]  lbp_data,
  output logic        finish
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_FILL  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [2:0] D_RIGHT = 3'b100;
  localparam logic [2:0] D_DOWN  = 3'b010;
  localparam logic [2:0] D_LEFT  = 3'b001;

  localparam logic [13:0] START = {7'd1, 7'd1};
  localparam logic [6:0]  FIRST = 7'd1;
  localparam logic [6:0]  LAST  = 7'd126;

  logic [2:0]  state;
  logic [3:0]  cnt;
  logic [1:0]  k;
  logic [2:0]  dir;
  logic [13:0] addr_a;
  logic [13:0] addr_b;
  logic [13:0] addr_c;
  logic [7:0]  w [3][3];

  logic [6:0]  row;
  logic [6:0]  col;
  logic [2:0]  mv_dir;
  logic [13:0] mv_addr;
  logic        mv_last;
  logic [3:0]  init_n;
  logic [1:0]  init_r;
  logic [1:0]  init_c;
  logic [1:0]  slot;
  logic [7:0]  code;

  // Bitwise 2-of-3 vote across the address copies
  assign lbp_addr = (addr_a & addr_b) |
                    (addr_a & addr_c) |
                    (addr_b & addr_c);

  assign row = lbp_addr[13:7];
  assign col = lbp_addr[6:0];

  always_comb begin
    mv_dir  = D_RIGHT;
    mv_addr = lbp_addr;
    mv_last = 1'b0;
    unique case (1'b1)
      row[0] && (col < LAST): begin
        mv_dir  = D_RIGHT;
        mv_addr = {row, col + 7'd1};
      end
      row[0] && (col >= LAST): begin
        mv_dir  = D_DOWN;
        mv_addr = {row + 7'd1, col};
      end
      !row[0] && (col > FIRST): begin
        mv_dir  = D_LEFT;
        mv_addr = {row, col - 7'd1};
      end
      !row[0] && (col <= FIRST) && (row < LAST): begin
        mv_dir  = D_DOWN;
        mv_addr = {row + 7'd1, col};
      end
      default: begin
        mv_last = 1'b1;
      end
    endcase
  end

  assign init_n = cnt - 4'd1;

  always_comb begin
    init_r = 2'd0;
    init_c = init_n[1:0];
    if (init_n >= 4'd6) begin
      init_r = 2'd2;
      init_c = 2'(init_n - 4'd6);
    end else if (init_n >= 4'd3) begin
      init_r = 2'd1;
      init_c = 2'(init_n - 4'd3);
    end
  end

  // Registered generator address: data for step k lands at k+1
  assign slot = k - 2'd1;

  always_comb begin
    code[0] = w[0][0] >= w[1][1];
    code[1] = w[0][1] >= w[1][1];
    code[2] = w[0][2] >= w[1][1];
    code[3] = w[1][0] >= w[1][1];
    code[4] = w[1][2] >= w[1][1];
    code[5] = w[2][0] >= w[1][1];
    code[6] = w[2][1] >= w[1][1];
    code[7] = w[2][2] >= w[1][1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      k      <= 2'd0;
      dir    <= 3'b000;
      addr_a <= 14'd0;
      addr_b <= 14'd0;
      addr_c <= 14'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (gray_ready) begin
            state  <= S_INIT;
            cnt    <= 4'd1;
            addr_a <= START;
            addr_b <= START;
            addr_c <= START;
          end
        end
        S_INIT: begin
          if (cnt == 4'd9) begin
            state <= S_WRITE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_WRITE: begin
          if (mv_last) begin
            state <= S_DONE;
          end else begin
            state  <= S_FILL;
            k      <= 2'd0;
            dir    <= mv_dir;
            addr_a <= mv_addr;
            addr_b <= mv_addr;
            addr_c <= mv_addr;
          end
        end
        S_FILL: begin
          if (k == 2'd3) begin
            state <= S_WRITE;
            k     <= 2'd0;
          end else begin
            k <= k + 2'd1;
          end
        end
        default: begin
          state <= S_DONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          w[i][j] <= 8'd0;
        end
      end
    end else begin
      case (state)
        S_INIT: begin
          w[init_r][init_c] <= gray_data;
        end
        S_WRITE: begin
          if (!mv_last) begin
            case (mv_dir)
              D_RIGHT: begin
                for (int i = 0; i < 3; i++) begin
                  w[i][0] <= w[i][1];
                  w[i][1] <= w[i][2];
                end
              end
              D_LEFT: begin
                for (int i = 0; i < 3; i++) begin
                  w[i][2] <= w[i][1];
                  w[i][1] <= w[i][0];
                end
              end
              default: begin
                for (int j = 0; j < 3; j++) begin
                  w[0][j] <= w[1][j];
                  w[1][j] <= w[2][j];
                end
              end
            endcase
          end
        end
        S_FILL: begin
          if (k != 2'd0) begin
            case (dir)
              D_RIGHT: w[slot][2] <= gray_data;
              D_LEFT:  w[slot][0] <= gray_data;
              default: w[2][slot] <= gray_data;
            endcase
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign initialize   = (state == S_INIT);
  assign gray_req     = (state == S_INIT) ||
                        (state == S_WRITE) ||
                        (state == S_FILL);
  assign gray_addr_en = (state == S_FILL) && (k != 2'd3);
  assign fill_right   = (state == S_FILL) && dir[2];
  assign fill_down    = (state == S_FILL) && dir[1];
  assign fill_left    = (state == S_FILL) && dir[0];
  assign cycle        = initialize   ? cnt :
                        gray_addr_en ? {2'b00, k} : 4'd0;
  assign lbp_valid    = (state == S_WRITE);
  assign lbp_data     = lbp_valid ? code : 8'd0;
  assign finish       = (state == S_DONE);

endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Bench for lbp_scan_ctrl: image/generator model plus a queue of
// expected (address, code) pairs checked on every write strobe.
module tb_lbp_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        gray_ready;
  logic [7:0]  gray_data;
  logic        gray_req;
  logic        initialize;
  logic        fill_right;
  logic        fill_down;
  logic        fill_left;
  logic        gray_addr_en;
  logic [3:0]  cycle;
  logic [13:0] lbp_addr;
  logic        lbp_valid;
  logic [7:0]  lbp_data;
  logic        finish;

  lbp_scan_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .gray_ready   (gray_ready),
    .gray_data    (gray_data),
    .gray_req     (gray_req),
    .initialize   (initialize),
    .fill_right   (fill_right),
    .fill_down    (fill_down),
    .fill_left    (fill_left),
    .gray_addr_en (gray_addr_en),
    .cycle        (cycle),
    .lbp_addr     (lbp_addr),
    .lbp_valid    (lbp_valid),
    .lbp_data     (lbp_data),
    .finish       (finish)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  img [0:16383];
  int          n_assert = 0;
  int          n_fail = 0;
  int          strobes = 0;
  int          tick = 0;
  int          t0 = 0;
  logic [13:0] exp_center = '0;
  logic [2:0]  exp_dir = '0;

  function automatic logic [13:0] next_pos(input logic [13:0] a);
    logic [6:0] r;
    logic [6:0] c;
    r = a[13:7];
    c = a[6:0];
    if (r[0]) begin
      if (c < 7'd126) c = c + 7'd1;
      else r = r + 7'd1;
    end else begin
      if (c > 7'd1) c = c - 7'd1;
      else r = r + 7'd1;
    end
    return {r, c};
  endfunction

  function automatic logic [2:0] move_dir(input logic [13:0] a);
    if (a[7]) return (a[6:0] < 7'd126) ? 3'b100 : 3'b010;
    return (a[6:0] > 7'd1) ? 3'b001 : 3'b010;
  endfunction

  function automatic logic [7:0] model_lbp(input logic [13:0] a);
    int dr[8];
    int dc[8];
    int r;
    int c;
    logic [7:0] gc;
    logic [7:0] res;
    dr = '{-1, -1, -1, 0, 0, 1, 1, 1};
    dc = '{-1, 0, 1, -1, 1, -1, 0, 1};
    r = int'(a[13:7]);
    c = int'(a[6:0]);
    gc = img[r * 128 + c];
    for (int p = 0; p < 8; p++)
      res[p] = img[(r + dr[p]) * 128 + c + dc[p]] >= gc;
    return res;
  endfunction

  // Address generator model: combinational in INIT, registered in FILL
  logic [13:0] gaddr = '0;
  logic [3:0]  cm1;
  logic [13:0] init_idx;

  assign cm1 = cycle - 4'd1;
  assign init_idx = {7'(cm1 / 4'd3), 7'(cm1 % 4'd3)};
  assign gray_data = initialize ? img[init_idx] : img[gaddr];

  always @(posedge clk) begin
    tick = tick + 1;
    if (gray_addr_en) begin
      if (fill_down)
        gaddr <= {lbp_addr[13:7] + 7'd1,
                  lbp_addr[6:0] - 7'd1 + 7'(cycle)};
      else if (fill_right)
        gaddr <= {lbp_addr[13:7] - 7'd1 + 7'(cycle),
                  lbp_addr[6:0] + 7'd1};
      else
        gaddr <= {lbp_addr[13:7] - 7'd1 + 7'(cycle),
                  lbp_addr[6:0] - 7'd1};
    end
  end

  always @(negedge clk) begin
    if (!reset && lbp_valid) begin
      exp_t e;
      strobes = strobes + 1;
      n_assert++;
      assert (q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_extra_strobe observed=%0d expected=empty", lbp_addr);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        n_assert++;
        assert (lbp_addr === e.addr) else begin
          n_fail++;
          $error("FAIL sb_addr observed=%0d expected=%0d", lbp_addr, e.addr);
        end
        n_assert++;
        assert (lbp_data === e.data) else begin
          n_fail++;
          $error("FAIL sb_data@%0d observed=%0d expected=%0d",
                 e.addr, lbp_data, e.data);
        end
        exp_center = next_pos(e.addr);
        exp_dir = move_dir(e.addr);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && gray_addr_en && cycle == 4'd0) begin
      n_assert++;
      assert ({fill_right, fill_down, fill_left} === exp_dir) else begin
        n_fail++;
        $error("FAIL move_dir observed=%b expected=%b",
               {fill_right, fill_down, fill_left}, exp_dir);
      end
      n_assert++;
      assert (lbp_addr === exp_center) else begin
        n_fail++;
        $error("FAIL next_center observed=%0d expected=%0d",
               lbp_addr, exp_center);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_img(input int mode);
    for (int r = 0; r < 128; r++)
      for (int c = 0; c < 128; c++)
        case (mode)
          0: img[r * 128 + c] = 8'd50;
          1: img[r * 128 + c] = 8'(c);
          2: img[r * 128 + c] = 8'(r);
          default: img[r * 128 + c] = 8'($urandom_range(0, 7));
        endcase
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, 32'(lbp_valid), 0);
    chk({tag, "_addr"}, 32'(lbp_addr), 0);
    chk({tag, "_data"}, 32'(lbp_data), 0);
    chk({tag, "_req"}, 32'(gray_req), 0);
    chk({tag, "_cycle"}, 32'(cycle), 0);
    chk({tag, "_finish"}, 32'(finish), 0);
    chk({tag, "_ctl"}, 32'({initialize, fill_right, fill_down,
                            fill_left, gray_addr_en}), 0);
  endtask

  task automatic start_scan(input int n);
    logic [13:0] a;
    int g;
    q.delete();
    a = {7'd1, 7'd1};
    for (int i = 0; i < n; i++) begin
      q.push_back('{addr: a, data: model_lbp(a)});
      a = next_pos(a);
    end
    strobes = 0;
    @(negedge clk);
    gray_ready = 1'b1;
    @(posedge clk);
    #1;
    t0 = tick;
    gray_ready = 1'b0;
    g = 0;
    while (g < 20) begin
      @(negedge clk);
      g++;
      if (lbp_valid) break;
    end
    chk("first_write_cycle", 32'(g), 10);
  endtask

  task automatic wait_strobes(input int n, input string tag);
    int g;
    g = 0;
    while (strobes < n && g < n * 5 + 40) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk(tag, 32'(strobes), 32'(n));
  endtask

  task automatic reset_now(input string tag);
    chk({tag, "_pre_valid"}, 32'(lbp_valid), 1);
    reset = 1'b1;
    #1;
    check_idle_outputs(tag);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int g;
    reset = 1'b1;
    gray_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("idle_hold");

    load_img(0);
    start_scan(300);
    wait_strobes(300, "flat_strobes");
    reset_now("flat_rst");

    load_img(1);
    start_scan(300);
    wait_strobes(300, "colgrad_strobes");
    reset_now("colgrad_rst");

    load_img(2);
    start_scan(300);
    wait_strobes(300, "rowgrad_strobes");
    reset_now("rowgrad_rst");

    load_img(3);
    start_scan(500);
    wait_strobes(500, "mid_strobes");
    reset_now("mid_rst");
    repeat (4) @(negedge clk);
    chk("no_restart_without_ready", 32'(gray_req), 0);

    start_scan(15876);
    wait_strobes(1000, "tmr_reach");
    g = 0;
    while (!(gray_addr_en && cycle == 4'd1) && g < 10) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("tmr_fill_found", 32'(gray_addr_en), 1);
    force dut.addr_b = 14'h3FFF;
    #1;
    chk("tmr_vote_k1", 32'(lbp_addr), 32'(exp_center));
    @(negedge clk);
    #1;
    chk("tmr_vote_k2", 32'(lbp_addr), 32'(exp_center));
    release dut.addr_b;

    g = 0;
    while (!finish && g < 80000) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk("finish_seen", 32'(finish), 1);
    chk("finish_cycle", 32'(tick - t0 + 1), 10 + 15875 * 5 + 1);
    chk("total_strobes", 32'(strobes), 15876);
    chk("sb_drained", 32'(q.size()), 0);
    chk("done_req", 32'(gray_req), 0);
    gray_ready = 1'b1;
    repeat (3) @(negedge clk);
    gray_ready = 1'b0;
    chk("finish_sticky", 32'(finish), 1);
    chk("done_ignores_ready", 32'(strobes), 15876);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
